// File: rtl/fifo_pkt_pkg.sv
// Shared types and width helpers for the FIFO packetizer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkt_pkg;

    // Holding-register occupancy.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } fifo_pkt_state_e;

    // Beat counter width. It must hold 0..max_len-1 and is never narrower than one bit.
    function automatic int cnt_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

    // Idle timer width. It must hold 0..timeout inclusive, because it saturates at timeout.
    function automatic int tmr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_pkt_idle_timer.sv
// Idle timer: counts cycles while run is high and saturates at P_TIMEOUT; hit flags saturation.
// Latency: hit rises one cycle after the P_TIMEOUT-th running cycle; clear takes effect on the next edge.
// Backpressure: none; clear wins over run.
// Ports: clk, rst (sync, active-high), run (count enable), clear (zero the count), hit (count == P_TIMEOUT).
module fifo_pkt_idle_timer
    import fifo_pkt_pkg::*;
#(
    parameter int P_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic hit
);

    localparam int TW = tmr_width(P_TIMEOUT);
    localparam logic [TW-1:0] LIMIT = TW'(P_TIMEOUT);

    logic [TW-1:0] idle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else if (clear) begin
            idle_q <= '0;
        end else if (run && (idle_q != LIMIT)) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign hit = (idle_q == LIMIT);

endmodule

// File: rtl/fifo_packetizer.sv
// Packet framer: pops a FWFT FIFO and emits a valid/ready stream, closing packets on max length, flush or idle timeout.
// Latency: at least 2 cycles from FIFO head to m_valid (pop into hold_q, then advance to the output register).
// Backpressure: m_valid && !m_ready freezes the output and holding stages; no pops happen while the hold is full and blocked.
// Ports: clk, rst (sync, active-high); fifo_data/fifo_empty/fifo_rd_en (FIFO read side);
//        flush (one-cycle close request); m_valid/m_data/m_last/m_ready (output stream).
// Option: define FIFO_PKT_TIMEOUT_EN to close an open packet after P_TIMEOUT idle cycles with the FIFO empty.
module fifo_packetizer
    import fifo_pkt_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_MAX_LEN    = 16,
    parameter int P_TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_DATA_WIDTH-1:0] fifo_data,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic                    m_valid,
    output logic [P_DATA_WIDTH-1:0] m_data,
    output logic                    m_last,
    input  logic                    m_ready
);

    localparam int CW = cnt_width(P_MAX_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(P_MAX_LEN - 1);

    if (P_MAX_LEN < 1 || P_TIMEOUT < 1) begin : g_bad_params
        $error("fifo_packetizer: P_MAX_LEN and P_TIMEOUT must both be at least 1");
    end

    fifo_pkt_state_e         state_q;
    logic [P_DATA_WIDTH-1:0] hold_q;
    logic [CW-1:0]           cnt_q;
    logic                    flush_pend_q;
    logic                    timeout_hit;

    logic held;
    logic out_free;
    logic at_max;
    logic close;
    logic last_beat;
    logic adv;

    assign held      = (state_q == S_HELD);
    assign out_free  = !m_valid || m_ready;
    assign at_max    = (cnt_q == LAST_CNT);
    assign close     = flush_pend_q || flush || timeout_hit;
    assign last_beat = at_max || close;

    // A held word moves out only when we can already decide its m_last:
    // a successor is waiting, the packet is full, or a close is requested.
    assign adv = held && out_free && (!fifo_empty || at_max || close);

    // With the FIFO non-empty, advancing reduces to held && out_free, so the
    // pop is written without the close term and has no path from flush or the timer.
    assign fifo_rd_en = !rst && !fifo_empty && (!held || out_free);

`ifdef FIFO_PKT_TIMEOUT_EN
    fifo_pkt_idle_timer #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (held && fifo_empty),
        .clear (fifo_rd_en || !held),
        .hit   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            hold_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                hold_q <= fifo_data;
            end

            // m_data and m_last are left as they are when the beat drains, so they only change on an advance.
            if (adv) begin
                m_valid <= 1'b1;
                m_data  <= hold_q;
                m_last  <= last_beat;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (adv) begin
                cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
            end

            // A flush can never meet a non-last advance, because flush itself forces last.
            if (adv && last_beat) begin
                flush_pend_q <= 1'b0;
            end else if (flush && held) begin
                flush_pend_q <= 1'b1;
            end

            case (state_q)
                S_EMPTY: if (fifo_rd_en)          state_q <= S_HELD;
                S_HELD:  if (adv && !fifo_rd_en)  state_q <= S_EMPTY;
                default:                          state_q <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Self-checking bench for fifo_packetizer: a queue-based FWFT FIFO drives the DUT, and a scoreboard holds the expected beats.
// Latency: n/a.
// Backpressure: m_ready is driven by directed phases and then randomised.
module tb_fifo_packetizer;

    localparam int DW = 32;
    localparam int ML = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;

    beat_t         exp_q[$];
    logic [DW-1:0] fq[$];
    int            checks = 0;
    int            fails = 0;
    int            out_cnt = 0;
    int            cyc = 0;
    bit            rdy_rand = 1'b0;
    bit            watch_on = 1'b0;
    bit            watch_hit = 1'b0;
    logic [DW-1:0] watch_word = '0;
    int            watch_cyc = 0;

    always #5 clk = ~clk;

    fifo_packetizer #(
        .P_DATA_WIDTH (DW),
        .P_MAX_LEN    (ML),
        .P_TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO read side: pop on the active edge and republish the head on the falling edge.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            if (watch_on && fq[0] == watch_word) begin
                watch_cyc = cyc;
                watch_hit = 1'b1;
            end
            void'(fq.pop_front());
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (fifo_rd_en) check("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    end

    // Monitor: every accepted output beat is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {32'd0, m_data}, 64'hDEAD);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", {32'd0, m_data}, {32'd0, e.d});
                check("out_last", {63'd0, m_last}, {63'd0, e.l});
            end
            out_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = ($urandom_range(3) != 0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit last);
        fq.push_back(w);
        exp_q.push_back('{d: w, l: last});
    endtask

    // One packet of len words. The last word is expected with m_last, and a flush supplies that close when len < ML.
    task automatic push_pkt(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            push_word($urandom, i == len - 1);
            if (gaps) repeat ($urandom_range(3)) tick();
        end
    endtask

    // Wait until the final word has been popped into the holding register, then pulse flush.
    task automatic close_pkt();
        int n = 0;
        while (fq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("fifo_drained_before_flush", fq.size(), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            sample();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] held_data;
        int            n;
        int            base;

        // Reset state
        repeat (3) tick();
        sample();
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_last", {63'd0, m_last}, 64'd0);
        check("rst_m_data", {32'd0, m_data}, 64'd0);
        check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        tick();
        rst = 1'b0;

        // Streaming: 8 preloaded words form two full packets with no bubbles
        m_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) push_word(DW'(i), (i % ML) == ML - 1);
        n = 0;
        do begin
            sample();
            n++;
        end while (!m_valid && n < 20);
        for (int i = 0; i < 7; i++) begin
            sample();
            check("stream_no_bubble", {63'd0, m_valid}, 64'd1);
        end
        wait_drain("stream_drain");

        // Backpressure: output and holding register fill, then everything stalls
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'hB000_0000 + DW'(i), i == ML - 1 || i == 5);
        repeat (4) sample();
        held_data = m_data;
        check("bp_fifo_level", fq.size(), 4);
        for (int i = 0; i < 10; i++) begin
            sample();
            check("bp_m_valid", {63'd0, m_valid}, 64'd1);
            check("bp_data_stable", {32'd0, m_data}, {32'd0, held_data});
            check("bp_rd_en_low", {63'd0, fifo_rd_en}, 64'd0);
        end
        tick();
        m_ready = 1'b1;
        close_pkt();
        wait_drain("bp_drain");

        // Flush: [X,Y] closes on flush, and Z starts a fresh full packet
        push_word(32'hAAAA_0001, 1'b0);
        tick();
        push_word(32'hAAAA_0002, 1'b1);
        close_pkt();
        push_word(32'hAAAA_0003, 1'b0);
        push_pkt(ML - 1, 1'b0);
        wait_drain("flush_drain");

`ifdef FIFO_PKT_TIMEOUT_EN
        // Timeout: C is emitted with m_last 10 cycles after its pop
        tick();
        watch_word = 32'hC0C0_000C;
        watch_on   = 1'b1;
        watch_hit  = 1'b0;
        push_word(32'hC0C0_000A, 1'b0);
        push_word(32'hC0C0_000B, 1'b0);
        push_word(32'hC0C0_000C, 1'b1);
        n = 0;
        while (!watch_hit && n < 20) begin
            sample();
            n++;
        end
        check("timeout_pop_seen", {63'd0, watch_hit}, 64'd1);
        n = 0;
        while (!(m_valid && m_data == watch_word) && n < 40) begin
            sample();
            n++;
        end
        check("timeout_out_seen", {63'd0, m_valid && m_data == watch_word}, 64'd1);
        check("timeout_latency", 64'(cyc - watch_cyc), 64'd10);
        check("timeout_last", {63'd0, m_last}, 64'd1);
        watch_on = 1'b0;
        wait_drain("timeout_drain");
`else
        // No timer: a lone word waits until it is flushed
        tick();
        base = out_cnt;
        push_word(32'h5EED_0001, 1'b1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (m_valid) n++;
        end
        check("no_timeout_idle_valid", n, 0);
        check("no_timeout_idle_count", out_cnt - base, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain("no_timeout_flush_drain");
`endif

        // Reset mid-packet: the held word is lost, and the next 4 words form a full packet
        base = out_cnt;
        push_word(32'hD000_0000, 1'b0);
        push_word(32'hD000_0001, 1'b0);
        fq.push_back(32'hD000_0002);
        n = 0;
        while (out_cnt < base + 2 && n < 30) begin
            sample();
            n++;
        end
        check("midrst_two_out", out_cnt - base, 2);
        tick();
        rst = 1'b1;
        for (int i = 0; i < ML; i++) push_word(32'hE000_0000 + DW'(i), i == ML - 1);
        sample();
        check("midrst_rd_en_in_reset", {63'd0, fifo_rd_en}, 64'd0);
        tick();
        rst = 1'b0;
        sample();
        check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        check("midrst_expected", exp_q.size(), ML);
        wait_drain("midrst_drain");

        // Randomised packets with gaps and random backpressure
        rdy_rand = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int len;
            len = $urandom_range(ML, 1);
            push_pkt(len, 1'b1);
            if (len < ML) close_pkt();
        end
        rdy_rand = 1'b0;
        tick();
        m_ready = 1'b1;
        wait_drain("random_drain");
        repeat (5) sample();
        check("final_no_valid", {63'd0, m_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: actual still running at cycle %0d, required completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
